mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, data/address width; TIMEOUT, 255, max cycles in REQ+WAIT before abort.
REQ-002 i_clk  input  1  single clock; all state on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_if_req  input  1  fetch request, level, held until o_if_valid.
REQ-005 i_if_addr  input  WIDTH  fetch address, stable while i_if_req.
REQ-006 o_if_rdata  output  WIDTH  fetched instruction, valid with o_if_valid.
REQ-007 o_if_valid  output  1  one-cycle fetch completion pulse.
REQ-008 i_d_req  input  1  data request, level, held until o_d_valid.
REQ-009 i_d_we  input  1  1 = store, 0 = load.
REQ-010 i_d_addr  input  WIDTH  data address.
REQ-011 i_d_wdata  input  WIDTH  store data.
REQ-012 i_d_byteen  input  4  store byte enables.
REQ-013 o_d_rdata  output  WIDTH  load data, valid with o_d_valid.
REQ-014 o_d_valid  output  1  one-cycle data completion pulse (loads and stores).
REQ-015 o_stall  output  1  pipeline freeze request to core.
REQ-016 o_error  output  1  sticky timeout flag.
REQ-017 o_mem_req / o_mem_we / o_mem_addr / o_mem_wdata / o_mem_byteen  output  1/1/WIDTH/WIDTH/4  single shared memory port command.
REQ-018 i_mem_gnt  input  1  memory accepts command this cycle.
REQ-019 i_mem_rvalid / i_mem_rdata  input  1/WIDTH  memory response (also returned for stores).

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, RESP; one outstanding memory transaction maximum.
REQ-021 IDLE: if i_d_req, latch data request (owner=D) -> REQ; else if i_if_req, latch fetch (owner=IF, we=0, byteen=0) -> REQ; else stay.
REQ-022 Data SHALL have fixed priority over fetch when both are asserted in the same IDLE cycle.
REQ-023 REQ: o_mem_req=1 with latched command held stable; on i_mem_gnt -> WAIT.
REQ-024 WAIT: o_mem_req=0; on i_mem_rvalid, register i_mem_rdata into owner's rdata -> RESP.
REQ-025 RESP: pulse owner's valid exactly one cycle; next state IDLE; non-owner valid stays 0.
REQ-026 Minimum latency SHALL be 4 cycles from request sampled in IDLE to valid pulse (gnt and rvalid each in their first eligible cycle).
REQ-027 i_mem_rvalid outside WAIT and i_mem_gnt outside REQ SHALL be ignored.
REQ-028 o_d_rdata SHALL be 0 on store completion; rdata outputs hold value otherwise.
REQ-029 o_stall = (i_if_req && !o_if_valid) || (i_d_req && !o_d_valid), combinational.
REQ-030 A request still asserted in IDLE after its valid pulse SHALL be treated as a new request.
REQ-031 Cycle counter SHALL clear on entering REQ and increment in REQ/WAIT; at TIMEOUT, set o_error, drive owner's valid with rdata 0 via RESP, return to IDLE.
REQ-032 o_error SHALL remain 1 until reset.

Reset
REQ-033 Reset SHALL asynchronously force IDLE, counter 0, all outputs 0 including o_error, abandoning any in-flight transaction.
REQ-034 A response arriving after reset deassertion for an abandoned transaction SHALL be ignored (state IDLE).

Structure
REQ-035 State enum mem_arb_state_t and owner enum SHALL live in the shared type-enums package header.
REQ-036 Timeout counter SHALL be a sub-module mem_timeout_counter (clear, enable, expired output).

Verification
REQ-037 Fetch only: if_req, addr 0x100; gnt and rvalid immediate, rdata 0x00500093 -> o_if_valid at cycle 4, o_if_rdata 0x00500093, o_stall 1 for cycles 1-3.
REQ-038 Simultaneous: if_req addr 0x104, d_req load addr 0x2000 -> data serviced first (o_mem_addr 0x2000), then fetch 0x104; o_d_valid before o_if_valid.
REQ-039 Store: d_req we=1 addr 0x2004 wdata 0xDEADBEEF byteen 0xF, gnt delayed 3 cycles -> command stable during REQ; o_d_valid with o_d_rdata 0.
REQ-040 Timeout: TIMEOUT=8, gnt never asserted -> after 8 cycles o_error=1 sticky, owner valid pulses, rdata 0, FSM returns IDLE.
REQ-041 Reset in WAIT: assert i_reset mid-transaction, then late rvalid -> all outputs 0, no valid pulse.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data single-port memory arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } mem_arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } mem_owner_t;

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Cycle counter for the REQ/WAIT phases; expired flags the last allowed cycle.
module mem_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so a long stay after abort cannot wrap back to "alive".
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 1'b1;
    end

    assign expired = (count >= LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port,
// one outstanding transaction, data has fixed priority, sticky timeout error.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_if_req,
    input  logic [WIDTH-1:0] i_if_addr,
    output logic [WIDTH-1:0] o_if_rdata,
    output logic             o_if_valid,
    input  logic             i_d_req,
    input  logic             i_d_we,
    input  logic [WIDTH-1:0] i_d_addr,
    input  logic [WIDTH-1:0] i_d_wdata,
    input  logic [3:0]       i_d_byteen,
    output logic [WIDTH-1:0] o_d_rdata,
    output logic             o_d_valid,
    output logic             o_stall,
    output logic             o_error,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic [WIDTH-1:0] o_mem_wdata,
    output logic [3:0]       o_mem_byteen,
    input  logic             i_mem_gnt,
    input  logic             i_mem_rvalid,
    input  logic [WIDTH-1:0] i_mem_rdata
);
    mem_arb_state_t   state, state_nxt;
    mem_owner_t       owner;
    logic             cmd_we;
    logic [WIDTH-1:0] cmd_addr, cmd_wdata;
    logic [3:0]       cmd_byteen;
    logic             take_d, take_if, cnt_clear, cnt_en, expired;
    logic             abort, finish;
    logic [WIDTH-1:0] finish_data;

    mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (i_clk),
        .rst     (i_reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (expired)
    );

    // A grant on the last allowed cycle cannot complete in time, so expiry wins in REQ;
    // a response on the last allowed cycle still completes normally in WAIT.
    always_comb begin
        state_nxt   = state;
        take_d      = 1'b0;
        take_if     = 1'b0;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        abort       = 1'b0;
        finish      = 1'b0;
        finish_data = '0;
        case (state)
            IDLE: begin
                if (i_d_req) begin
                    take_d    = 1'b1;
                    cnt_clear = 1'b1;
                    state_nxt = REQ;
                end else if (i_if_req) begin
                    take_if   = 1'b1;
                    cnt_clear = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                cnt_en = 1'b1;
                if (expired) begin
                    abort     = 1'b1;
                    finish    = 1'b1;
                    state_nxt = RESP;
                end else if (i_mem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                cnt_en = 1'b1;
                if (i_mem_rvalid) begin
                    finish      = 1'b1;
                    finish_data = cmd_we ? '0 : i_mem_rdata;
                    state_nxt   = RESP;
                end else if (expired) begin
                    abort     = 1'b1;
                    finish    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_byteen <= '0;
            o_if_valid <= 1'b0;
            o_d_valid  <= 1'b0;
            o_if_rdata <= '0;
            o_d_rdata  <= '0;
            o_error    <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_if_valid <= 1'b0;
            o_d_valid  <= 1'b0;
            if (take_d) begin
                owner      <= OWN_D;
                cmd_we     <= i_d_we;
                cmd_addr   <= i_d_addr;
                cmd_wdata  <= i_d_wdata;
                cmd_byteen <= i_d_byteen;
            end else if (take_if) begin
                owner      <= OWN_IF;
                cmd_we     <= 1'b0;
                cmd_addr   <= i_if_addr;
                cmd_wdata  <= '0;
                cmd_byteen <= '0;
            end
            if (abort)
                o_error <= 1'b1;
            if (finish) begin
                if (owner == OWN_D) begin
                    o_d_valid <= 1'b1;
                    o_d_rdata <= finish_data;
                end else begin
                    o_if_valid <= 1'b1;
                    o_if_rdata <= finish_data;
                end
            end
        end
    end

    assign o_mem_req    = (state == REQ);
    assign o_mem_we     = o_mem_req & cmd_we;
    assign o_mem_addr   = o_mem_req ? cmd_addr   : '0;
    assign o_mem_wdata  = o_mem_req ? cmd_wdata  : '0;
    assign o_mem_byteen = o_mem_req ? cmd_byteen : '0;

    assign o_stall = (i_if_req && !o_if_valid) || (i_d_req && !o_d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// request mixes against a transaction-level timing/priority model.
module tb_mem_port_arbiter;
    localparam int W  = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_we, mem_gnt, mem_rvalid;
    logic [W-1:0]  if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]    d_be;
    logic [W-1:0]  if_rdata, d_rdata, mem_addr, mem_wdata;
    logic          if_valid, d_valid, stall, error, mem_req, mem_we;
    logic [3:0]    mem_be;

    int total = 0;
    int bad   = 0;
    bit          err_model;
    logic [W-1:0] exp_if_rd, exp_d_rd;

    mem_port_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_valid(if_valid),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .i_d_byteen(d_be), .o_d_rdata(d_rdata), .o_d_valid(d_valid),
        .o_stall(stall), .o_error(error),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_byteen(mem_be),
        .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: data requests (including re-requests of a held d_req) are all served
    // before fetch; each transaction occupies REQ for dg+1 cycles and WAIT for dr+1,
    // completing (valid) dg+dr+2 cycles after its command appears, or is aborted
    // after TO cycles of REQ+WAIT; the next command appears 2 cycles after a valid.
    task automatic run_seq(input string name, input int n_d, input int n_if,
                           input logic dwe, input logic [W-1:0] daddr, input logic [W-1:0] dwdata,
                           input logic [3:0] dbe, input logic [W-1:0] iaddr,
                           input int dg_lo, input int dg_hi, input int dr_lo, input int dr_hi,
                           input bit rnd_data, input logic [W-1:0] fix_data, input bit noise);
        int rem_d, rem_if, cyc, exp_cmd_at, t_cmd, e, dg, dr, lat;
        bit active, cur_d, is_to, exp_req, exp_dv, exp_iv, exp_stall;
        logic [W-1:0] mdata;
        rem_d = n_d; rem_if = n_if; active = 0; dg = 0; dr = 0; lat = 2; t_cmd = 0;
        cur_d = 0; is_to = 0; mdata = '0;
        mem_gnt = 0; mem_rvalid = 0; if_req = 0; d_req = 0;
        tick();
        d_we = dwe; d_addr = daddr; d_wdata = dwdata; d_be = dbe; if_addr = iaddr;
        d_req = (rem_d > 0); if_req = (rem_if > 0);
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL %s stall_at_request got=%b want=1", name, stall); end
        cyc = 0; exp_cmd_at = 1;
        while ((rem_d > 0 || rem_if > 0) && cyc < 300) begin
            tick();
            cyc++;
            if (!active && mem_req) begin
                active = 1; t_cmd = cyc; cur_d = (rem_d > 0);
                total++;
                if (cyc != exp_cmd_at) begin
                    bad++; $display("FAIL %s cmd_time got=%0d want=%0d", name, cyc, exp_cmd_at);
                end
                dg = $urandom_range(dg_hi, dg_lo);
                dr = $urandom_range(dr_hi, dr_lo);
                is_to = (dg + dr + 2 > TO);
                lat = is_to ? TO : dg + dr + 2;
                mdata = rnd_data ? $urandom : fix_data;
            end
            e = active ? cyc - t_cmd : -1;
            exp_req = active && e <= dg && e < lat;
            exp_dv  = active && cur_d && e == lat;
            exp_iv  = active && !cur_d && e == lat;
            if (active && e == lat) begin
                if (is_to) err_model = 1;
                if (cur_d) exp_d_rd = (is_to || dwe) ? '0 : mdata;
                else       exp_if_rd = is_to ? '0 : mdata;
            end
            exp_stall = (if_req && !exp_iv) || (d_req && !exp_dv);
            total += 7;
            if (mem_req !== exp_req)    begin bad++; $display("FAIL %s mem_req c%0d got=%b want=%b", name, cyc, mem_req, exp_req); end
            if (d_valid !== exp_dv)     begin bad++; $display("FAIL %s d_valid c%0d got=%b want=%b", name, cyc, d_valid, exp_dv); end
            if (if_valid !== exp_iv)    begin bad++; $display("FAIL %s if_valid c%0d got=%b want=%b", name, cyc, if_valid, exp_iv); end
            if (stall !== exp_stall)    begin bad++; $display("FAIL %s stall c%0d got=%b want=%b", name, cyc, stall, exp_stall); end
            if (error !== err_model)    begin bad++; $display("FAIL %s error c%0d got=%b want=%b", name, cyc, error, err_model); end
            if (d_rdata !== exp_d_rd)   begin bad++; $display("FAIL %s d_rdata c%0d got=%h want=%h", name, cyc, d_rdata, exp_d_rd); end
            if (if_rdata !== exp_if_rd) begin bad++; $display("FAIL %s if_rdata c%0d got=%h want=%h", name, cyc, if_rdata, exp_if_rd); end
            if (exp_req) begin
                total += 3;
                if (mem_addr !== (cur_d ? daddr : iaddr)) begin bad++; $display("FAIL %s mem_addr c%0d got=%h want=%h", name, cyc, mem_addr, cur_d ? daddr : iaddr); end
                if (mem_we !== (cur_d && dwe)) begin bad++; $display("FAIL %s mem_we c%0d got=%b want=%b", name, cyc, mem_we, cur_d && dwe); end
                if (mem_be !== (cur_d ? dbe : 4'h0)) begin bad++; $display("FAIL %s mem_byteen c%0d got=%h want=%h", name, cyc, mem_be, cur_d ? dbe : 4'h0); end
                if (cur_d) begin
                    total++;
                    if (mem_wdata !== dwdata) begin bad++; $display("FAIL %s mem_wdata c%0d got=%h want=%h", name, cyc, mem_wdata, dwdata); end
                end
            end
            if (active && e == lat) begin
                if (cur_d) begin rem_d--;  if (rem_d == 0)  d_req = 0;  end
                else       begin rem_if--; if (rem_if == 0) if_req = 0; end
                active = 0;
                exp_cmd_at = cyc + 2;
            end
            mem_gnt    = (active && e == dg) ||
                         (noise && (!active || e > dg) && ($urandom_range(1) == 1));
            mem_rvalid = (active && e == dg + 1 + dr) ||
                         (noise && (!active || e <= dg || e >= lat) && ($urandom_range(1) == 1));
            mem_rdata  = (active && e == dg + 1 + dr) ? mdata : $urandom;
        end
        mem_gnt = 0; mem_rvalid = 0;
        if (rem_d > 0 || rem_if > 0) begin
            total++; bad++;
            $display("FAIL %s completion_budget got=pending want=done", name);
        end
    endtask

    task automatic test_reset();
        rst = 1; if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
        d_be = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        err_model = 0; exp_if_rd = '0; exp_d_rd = '0;
        repeat (3) tick();
        total += 6;
        if (if_valid !== 1'b0) begin bad++; $display("FAIL reset if_valid got=%b want=0", if_valid); end
        if (d_valid !== 1'b0)  begin bad++; $display("FAIL reset d_valid got=%b want=0", d_valid); end
        if (error !== 1'b0)    begin bad++; $display("FAIL reset error got=%b want=0", error); end
        if (mem_req !== 1'b0)  begin bad++; $display("FAIL reset mem_req got=%b want=0", mem_req); end
        if (if_rdata !== '0 || d_rdata !== '0) begin bad++; $display("FAIL reset rdata got=%h/%h want=0", if_rdata, d_rdata); end
        if (stall !== 1'b0)    begin bad++; $display("FAIL reset stall got=%b want=0", stall); end
        rst = 0;
        tick();
    endtask

    task automatic test_fetch();
        run_seq("fetch", 0, 1, 0, '0, '0, 4'h0, 32'h100, 0, 0, 0, 0, 0, 32'h00500093, 0);
    endtask

    task automatic test_simultaneous();
        run_seq("simul", 1, 1, 0, 32'h2000, 32'h0, 4'hF, 32'h104, 0, 0, 0, 0, 1, '0, 0);
    endtask

    task automatic test_store();
        run_seq("store", 1, 0, 1, 32'h2004, 32'hDEADBEEF, 4'hF, 32'h0, 3, 3, 0, 0, 0, 32'h12345678, 0);
    endtask

    task automatic test_back_to_back();
        run_seq("b2b", 2, 2, 0, 32'h3000, 32'h0, 4'h3, 32'h200, 0, 2, 0, 2, 1, '0, 1);
    endtask

    task automatic test_deadline_edge();
        run_seq("deadline", 1, 0, 0, 32'h4000, 32'h0, 4'hC, 32'h0, 3, 3, 3, 3, 1, '0, 0);
    endtask

    task automatic test_random();
        int nd, ni;
        for (int it = 0; it < 25; it++) begin
            nd = $urandom_range(2);
            ni = (nd == 0) ? $urandom_range(2, 1) : $urandom_range(2);
            run_seq("random", nd, ni, 1'($urandom_range(1)), $urandom, $urandom, 4'($urandom),
                    $urandom, 0, 2, 0, 2, 1, '0, 1);
        end
    endtask

    task automatic test_timeout();
        run_seq("timeout_req", 0, 1, 0, '0, '0, 4'h0, 32'h500, 50, 50, 0, 0, 1, '0, 0);
        run_seq("timeout_wait", 1, 0, 0, 32'h600, '0, 4'hF, 32'h0, 1, 1, 50, 50, 1, '0, 0);
        run_seq("after_timeout", 1, 1, 1, 32'h700, 32'hCAFEF00D, 4'h5, 32'h708, 0, 1, 0, 1, 1, '0, 1);
    endtask

    task automatic test_reset_in_wait();
        logic sticky;
        tick();
        d_we = 0; d_addr = 32'h2008; d_be = 4'hF; d_req = 1;
        tick();
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        #2;
        rst = 1; d_req = 0;
        #1;
        sticky = error;
        total += 5;
        if (if_valid !== 1'b0 || d_valid !== 1'b0) begin bad++; $display("FAIL rst_wait valid got=%b/%b want=0", if_valid, d_valid); end
        if (mem_req !== 1'b0 || mem_addr !== '0) begin bad++; $display("FAIL rst_wait mem_cmd got=%b/%h want=0", mem_req, mem_addr); end
        if (sticky !== 1'b0) begin bad++; $display("FAIL rst_wait error got=%b want=0", sticky); end
        if (if_rdata !== '0 || d_rdata !== '0) begin bad++; $display("FAIL rst_wait rdata got=%h/%h want=0", if_rdata, d_rdata); end
        if (stall !== 1'b0) begin bad++; $display("FAIL rst_wait stall got=%b want=0", stall); end
        err_model = 0; exp_if_rd = '0; exp_d_rd = '0;
        @(negedge clk);
        rst = 0;
        mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_rvalid = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total += 3;
            if (d_valid !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL late_rvalid valid c%0d got=%b/%b want=0", k, d_valid, if_valid); end
            if (d_rdata !== '0) begin bad++; $display("FAIL late_rvalid d_rdata c%0d got=%h want=0", k, d_rdata); end
            if (mem_req !== 1'b0) begin bad++; $display("FAIL late_rvalid mem_req c%0d got=%b want=0", k, mem_req); end
        end
        run_seq("post_reset", 1, 0, 0, 32'h2010, '0, 4'hF, '0, 0, 0, 0, 0, 1, '0, 0);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store();
        test_back_to_back();
        test_deadline_edge();
        test_random();
        test_timeout();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
